// File: rtl/hack_alu_seq.sv
// hack_alu_seq: multi-cycle Hack ALU (zx, nx, zy, ny, f, no) over WIDTH bits,
// evaluated SLICE bits per enabled cycle with the carry rippled across cycles.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   ce                    clock enable, gates slice progression only
//   in_valid / in_ready   operand + control handshake
//   x, y                  operands
//   zx nx zy ny f no      Hack ALU control bits
//   out_valid / out_ready result handshake
//   out, zr, ng, cout     result, zero flag, negative flag, carry out (f=1 only)
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a new operation, operands latched on in_valid
// BUSY  | one slice per ce cycle, result built LSB slice first
// DONE  | result and flags held until out_ready
module hack_alu_seq #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng,
    output logic             cout
);

    localparam int N  = WIDTH / SLICE;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    if (WIDTH % SLICE != 0) begin : g_bad_cfg
        $error("hack_alu_seq: WIDTH must be a multiple of SLICE");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] xp, yp;
    logic             f_r, no_r;
    logic [IW-1:0]    idx;
    logic             carry;

    logic             load, step;
    logic [WIDTH-1:0] x_z, x_pre, y_z, y_pre;
    logic [SLICE-1:0] x_k, y_k, slice_res;
    logic [SLICE:0]   slice_sum;
    logic             carry_nxt;
    logic [WIDTH-1:0] result_nxt;

    assign x_z   = zx ? '0 : x;
    assign x_pre = nx ? ~x_z : x_z;
    assign y_z   = zy ? '0 : y;
    assign y_pre = ny ? ~y_z : y_z;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    load      = 1'b1;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (ce) begin
                    step = 1'b1;
                    if (idx == LAST) state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Slice datapath. The result register is rebuilt in place, so the
    // full-word view (for zr/ng on the last slice) is out with one slice replaced.
    always_comb begin
        x_k        = xp[idx*SLICE +: SLICE];
        y_k        = yp[idx*SLICE +: SLICE];
        slice_sum  = {1'b0, x_k} + {1'b0, y_k} + {{SLICE{1'b0}}, carry};
        slice_res  = f_r ? slice_sum[SLICE-1:0] : (x_k & y_k);
        if (no_r) slice_res = ~slice_res;
        carry_nxt  = f_r ? slice_sum[SLICE] : carry;
        result_nxt = out;
        result_nxt[idx*SLICE +: SLICE] = slice_res;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xp    <= '0;
            yp    <= '0;
            f_r   <= 1'b0;
            no_r  <= 1'b0;
            idx   <= '0;
            carry <= 1'b0;
            out   <= '0;
            zr    <= 1'b0;
            ng    <= 1'b0;
            cout  <= 1'b0;
        end else if (load) begin
            xp    <= x_pre;
            yp    <= y_pre;
            f_r   <= f;
            no_r  <= no;
            idx   <= '0;
            carry <= 1'b0;
        end else if (step) begin
            out   <= result_nxt;
            carry <= carry_nxt;
            if (idx == LAST) begin
                idx  <= '0;
                zr   <= (result_nxt == '0);
                ng   <= result_nxt[WIDTH-1];
                // carry is reported before the no inversion, and only for adds
                cout <= f_r & carry_nxt;
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

endmodule
